dshot_arming_controller: RTL and testbench

Sequencing controller between the DShot frame decoder and the motor output stage. Consumes each decoded frame, enforces the arming sequence (consecutive motor-stop frames), gates throttle, qualifies repeated special commands, and forces a failsafe stop when good frames stop arriving. All outputs are registered; throttle never leaves zero unless the block is armed.

---
 rtl/dshot_arming_controller.sv | 170 +++++++++++++++++
 tb/tb_dshot_arming_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dshot_arming_controller.sv
// rtl/dshot_arming_controller.sv - DShot frame sequencer: arming, throttle gating, command qualification, failsafe
module dshot_arming_controller #(
  parameter int ARM_FRAMES     = 10,
  parameter int CMD_REPEAT     = 6,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_strobe,
  input  logic [10:0] set_speed,
  input  logic [5:0]  special_command,
  input  logic        is_special_command,
  input  logic        crc_valid,
  input  logic        telemetry_bit,
  output logic [10:0] throttle,
  output logic        throttle_strobe,
  output logic        armed,
  output logic        failsafe,
  output logic [5:0]  cmd_out,
  output logic        cmd_strobe,
  output logic        telem_req,
  output logic [7:0]  crc_err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    ARM_TARGET  = 8'(ARM_FRAMES);
  localparam logic [3:0]    REP_TARGET  = 4'(CMD_REPEAT);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } ctrlState;

  ctrlState       state;
  logic [7:0]     armCount;
  logic [3:0]     repCount;
  logic [5:0]     trackedCmd;
  logic [TW-1:0]  timeoutCount;

  logic           goodFrame;
  logic           badFrame;
  logic           stopFrame;
  logic           cmdFrame;
  logic           throttleFrame;
  logic           timeoutReach;
  logic           sameCmd;
  logic [3:0]     repInc;
  logic [7:0]     armInc;

  assign goodFrame     = frame_strobe && crc_valid;
  assign badFrame      = frame_strobe && !crc_valid;
  assign stopFrame     = goodFrame && is_special_command && (special_command == 6'd0);
  assign cmdFrame      = goodFrame && is_special_command && (special_command != 6'd0);
  assign throttleFrame = goodFrame && !is_special_command;
  // Fires only on the edge the counter would step onto the limit; a good frame that cycle wins.
  assign timeoutReach  = !goodFrame && (timeoutCount == TIMEOUT_MAX - 1'b1);
  assign sameCmd       = (repCount != 4'd0) && (special_command == trackedCmd);
  assign repInc        = repCount + 4'd1;
  assign armInc        = armCount + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= DISARMED;
      armCount        <= 8'd0;
      repCount        <= 4'd0;
      trackedCmd      <= 6'd0;
      timeoutCount    <= '0;
      throttle        <= 11'd0;
      throttle_strobe <= 1'b0;
      armed           <= 1'b0;
      failsafe        <= 1'b0;
      cmd_out         <= 6'd0;
      cmd_strobe      <= 1'b0;
      telem_req       <= 1'b0;
      crc_err_count   <= 8'd0;
    end else begin
      throttle_strobe <= 1'b0;
      cmd_strobe      <= 1'b0;
      telem_req       <= goodFrame && telemetry_bit;

      if (badFrame && crc_err_count != 8'hFF)
        crc_err_count <= crc_err_count + 8'd1;

      if (goodFrame)
        timeoutCount <= '0;
      else if (timeoutCount != TIMEOUT_MAX)
        timeoutCount <= timeoutCount + 1'b1;

      // Command repeat tracking is independent of the arming state.
      if (cmdFrame) begin
        if (sameCmd) begin
          if (repCount != 4'd15)
            repCount <= repInc;
          if (repInc == REP_TARGET) begin
            cmd_out    <= special_command;
            cmd_strobe <= 1'b1;
          end
        end else begin
          trackedCmd <= special_command;
          repCount   <= 4'd1;
          if (REP_TARGET == 4'd1) begin
            cmd_out    <= special_command;
            cmd_strobe <= 1'b1;
          end
        end
      end else if (stopFrame || throttleFrame) begin
        repCount <= 4'd0;
      end

      case (state)
        DISARMED, FAILSAFE: begin
          if (stopFrame) begin
            armCount <= 8'd1;
            failsafe <= 1'b0;
            if (ARM_TARGET == 8'd1) begin
              state           <= ARMED;
              armed           <= 1'b1;
              throttle        <= 11'd0;
              throttle_strobe <= 1'b1;
            end else begin
              state <= ARMING;
            end
          end
        end

        ARMING: begin
          if (timeoutReach) begin
            state           <= FAILSAFE;
            armed           <= 1'b0;
            throttle        <= 11'd0;
            throttle_strobe <= 1'b1;
            failsafe        <= 1'b1;
            armCount        <= 8'd0;
          end else if (stopFrame) begin
            armCount <= armInc;
            if (armInc == ARM_TARGET) begin
              state           <= ARMED;
              armed           <= 1'b1;
              throttle        <= 11'd0;
              throttle_strobe <= 1'b1;
            end
          end else if (throttleFrame || cmdFrame) begin
            state    <= DISARMED;
            armCount <= 8'd0;
          end
        end

        ARMED: begin
          if (timeoutReach) begin
            state           <= FAILSAFE;
            armed           <= 1'b0;
            throttle        <= 11'd0;
            throttle_strobe <= 1'b1;
            failsafe        <= 1'b1;
            armCount        <= 8'd0;
          end else if (goodFrame) begin
            throttle_strobe <= 1'b1;
            throttle        <= throttleFrame ? set_speed : 11'd0;
          end
        end

        default: state <= DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_dshot_arming_controller.sv
// tb/tb_dshot_arming_controller.sv - randomized and directed bench for dshot_arming_controller against a behavioural model
module tb_dshot_arming_controller;

  localparam int ARM = 10;
  localparam int REP = 6;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_strobe = 1'b0;
  logic [10:0] set_speed = 11'd0;
  logic [5:0]  special_command = 6'd0;
  logic        is_special_command = 1'b0;
  logic        crc_valid = 1'b0;
  logic        telemetry_bit = 1'b0;
  logic [10:0] throttle;
  logic        throttle_strobe;
  logic        armed;
  logic        failsafe;
  logic [5:0]  cmd_out;
  logic        cmd_strobe;
  logic        telem_req;
  logic [7:0]  crc_err_count;

  dshot_arming_controller #(
    .ARM_FRAMES(ARM), .CMD_REPEAT(REP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_strobe(frame_strobe), .set_speed(set_speed),
    .special_command(special_command), .is_special_command(is_special_command),
    .crc_valid(crc_valid), .telemetry_bit(telemetry_bit), .throttle(throttle),
    .throttle_strobe(throttle_strobe), .armed(armed), .failsafe(failsafe),
    .cmd_out(cmd_out), .cmd_strobe(cmd_strobe), .telem_req(telem_req),
    .crc_err_count(crc_err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: arming progress as a run length of stop frames, idle time as a plain cycle count.
  bit mArmed, mFailsafe;
  int mStopRun, mIdle, mCmdRun, mLastCmd, mErrs, mThr, mCmdOut;
  bit eTs, eCs, eTelem;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mArmed = 0; mFailsafe = 0; mStopRun = 0; mIdle = 0; mCmdRun = 0; mLastCmd = -1;
    mErrs = 0; mThr = 0; mCmdOut = 0; eTs = 0; eCs = 0; eTelem = 0;
  endtask

  task automatic modelStep(input bit fs, input bit crc, input bit special, input int cmd,
                           input int speed, input bit telem);
    bit good, isStop, isCmd, isThr;
    good = fs && crc;
    isStop = good && special && cmd == 0;
    isCmd  = good && special && cmd != 0;
    isThr  = good && !special;
    eTs = 0; eCs = 0;
    eTelem = good && telem;
    if (fs && !crc && mErrs < 255) mErrs++;
    if (good) mIdle = 0; else mIdle++;

    if (isCmd) begin
      if (mCmdRun > 0 && cmd == mLastCmd) mCmdRun++;
      else begin mLastCmd = cmd; mCmdRun = 1; end
      if (mCmdRun == REP) begin mCmdOut = cmd; eCs = 1; end
    end else if (isStop || isThr) mCmdRun = 0;

    if (!good && mIdle == TO && (mArmed || mStopRun > 0)) begin
      mArmed = 0; mThr = 0; eTs = 1; mFailsafe = 1; mStopRun = 0;
    end else if (good) begin
      if (mArmed) begin
        eTs = 1;
        mThr = isThr ? speed : 0;
      end else if (isStop) begin
        mStopRun++;
        mFailsafe = 0;
        if (mStopRun == ARM) begin mArmed = 1; mThr = 0; eTs = 1; end
      end else if (mStopRun > 0) begin
        mStopRun = 0;
      end
    end
  endtask

  task automatic compareAll();
    chk("throttle", throttle, mThr);
    chk("throttle_strobe", throttle_strobe, eTs);
    chk("armed", armed, mArmed);
    chk("failsafe", failsafe, mFailsafe);
    chk("cmd_out", cmd_out, mCmdOut);
    chk("cmd_strobe", cmd_strobe, eCs);
    chk("telem_req", telem_req, eTelem);
    chk("crc_err_count", crc_err_count, mErrs);
  endtask

  task automatic step(input bit fs, input bit crc, input bit special, input int cmd,
                      input int speed, input bit telem);
    frame_strobe = fs;
    crc_valid = crc;
    is_special_command = special;
    special_command = 6'(cmd);
    set_speed = 11'(speed);
    telemetry_bit = telem;
    modelStep(fs, crc, special, cmd, speed, telem);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic stopF();
    step(1, 1, 1, 0, $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
  endtask
  task automatic thrF(input int sp);
    step(1, 1, 0, $urandom_range(0, 63), sp, 1'($urandom_range(0, 1)));
  endtask
  task automatic cmdF(input int c);
    step(1, 1, 1, c, $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
  endtask
  task automatic badF(input int sp);
    step(1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 47), sp, 1'($urandom_range(0, 1)));
  endtask
  task automatic idleF(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 47),
           $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
  endtask

  task automatic randFrame();
    int k;
    bit fs, crc;
    fs = $urandom_range(0, 1);
    crc = $urandom_range(0, 99) < 85;
    k = $urandom_range(0, 2);
    if (k == 0) step(fs, crc, 1, 0, $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
    else if (k == 1) step(fs, crc, 1, $urandom_range(1, 47), 0, 1'($urandom_range(0, 1)));
    else step(fs, crc, 0, 0, $urandom_range(0, 1999), 1'($urandom_range(0, 1)));
  endtask

  task automatic doReset();
    reset_n = 0;
    frame_strobe = 0;
    #2;
    modelReset();
    compareAll();
    @(posedge clk);
    #1;
    compareAll();
    reset_n = 1;
  endtask

  initial begin
    modelReset();
    @(posedge clk);
    #1;
    compareAll();
    chk("reset_armed", armed, 0);
    chk("reset_crc", crc_err_count, 0);
    reset_n = 1;

    // Arming threshold
    for (int i = 0; i < ARM - 1; i++) stopF();
    chk("nine_stops_unarmed", armed, 0);
    stopF();
    chk("tenth_stop_armed", armed, 1);
    chk("arm_throttle_strobe", throttle_strobe, 1);

    thrF(1000);
    chk("throttle_1000", throttle, 1000);
    badF(0);
    chk("bad_keeps_throttle", throttle, 1000);
    chk("bad_counted", crc_err_count, 1);

    // Timeout from armed
    idleF(TO);
    chk("timeout_failsafe", failsafe, 1);
    chk("timeout_disarm", armed, 0);
    idleF(3);
    stopF();
    chk("stop_clears_failsafe", failsafe, 0);

    // Throttle mid-arming aborts
    doReset();
    for (int i = 0; i < 5; i++) stopF();
    thrF(1500);
    chk("abort_unarmed", armed, 0);
    chk("abort_throttle0", throttle, 0);
    for (int i = 0; i < ARM; i++) stopF();
    chk("rearm_after_abort", armed, 1);

    // Good frame coincident with saturation wins
    idleF(TO - 1);
    thrF(500);
    chk("coincident_no_failsafe", failsafe, 0);
    idleF(TO - 1);
    chk("still_armed_limit_minus1", armed, 1);
    idleF(1);
    chk("limit_failsafe", failsafe, 1);

    // Command qualification
    for (int i = 0; i < REP; i++) cmdF(7);
    chk("cmd7_out", cmd_out, 7);
    cmdF(7);
    chk("cmd7_no_repeat", cmd_strobe, 0);
    for (int i = 0; i < 5; i++) cmdF(7);
    cmdF(8);
    for (int i = 0; i < 5; i++) cmdF(8);
    chk("cmd8_out", cmd_out, 8);

    // Telemetry pulse
    step(1, 1, 0, 0, 100, 1);
    chk("telem_pulse", telem_req, 1);
    idleF(1);
    chk("telem_one_cycle", telem_req, 0);

    // CRC counter saturation
    for (int i = 0; i < 300; i++) badF($urandom_range(0, 2047));
    chk("crc_saturate", crc_err_count, 255);

    // Reset mid-sequence
    for (int i = 0; i < 4; i++) stopF();
    doReset();

    // Randomized segments
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 5))
        0: for (int i = 0; i < 12; i++) begin
             if ($urandom_range(0, 9) != 0) stopF(); else randFrame();
           end
        1: for (int i = 0; i < 20; i++) randFrame();
        2: idleF($urandom_range(150, 210));
        3: begin
             int c;
             c = $urandom_range(1, 47);
             for (int i = 0; i < $urandom_range(4, 8); i++) begin
               if ($urandom_range(0, 7) == 0) badF(0);
               cmdF(c);
             end
           end
        4: for (int i = 0; i < 10; i++) thrF($urandom_range(0, 1999));
        default: begin
             if ($urandom_range(0, 9) == 0) doReset();
             for (int i = 0; i < 15; i++) begin
               if ($urandom_range(0, 9) < 3) randFrame(); else idleF(1);
             end
           end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
